// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared types and constants for the interrupt entry sequencer
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DUMMY1   = 3'd1,
    ST_DUMMY2   = 3'd2,
    ST_PUSH_PCH = 3'd3,
    ST_PUSH_PCL = 3'd4,
    ST_PUSH_P   = 3'd5,
    ST_VEC_LO   = 3'd6,
    ST_VEC_HI   = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    SRC_RESET = 2'd0,
    SRC_NMI   = 2'd1,
    SRC_BRK   = 2'd2,
    SRC_IRQ   = 2'd3
  } int_source_t;

  localparam logic [1:0] DSEL_NONE = 2'd0;
  localparam logic [1:0] DSEL_PCH  = 2'd1;
  localparam logic [1:0] DSEL_PCL  = 2'd2;
  localparam logic [1:0] DSEL_PSR  = 2'd3;

  localparam logic [15:0] DEF_NMI_VECTOR   = 16'hFFFA;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;
  localparam logic [7:0]  DEF_STACK_PAGE   = 8'h01;

endpackage

// File: rtl/nmi_edge_latch.sv
// rtl/nmi_edge_latch.sv - NMI rising-edge detector with sticky pending flag
module nmi_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic nmi_in,
  input  logic clear,
  output logic pending
);

  logic nmi_q;
  logic pending_q;
  logic pending_d;
  logic rise;

  assign rise = nmi_in & ~nmi_q;

  // A new edge in the commit cycle must survive, so set is applied after clear.
  always_comb begin
    pending_d = pending_q;
    if (clear) pending_d = 1'b0;
    if (rise)  pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    nmi_q <= nmi_in;
    if (reset) pending_q <= 1'b0;
    else       pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - arbitrates RESET/NMI/BRK/IRQ and sequences the 7-cycle handler entry
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [15:0] NMI_VECTOR   = DEF_NMI_VECTOR,
  parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR,
  parameter logic [7:0]  STACK_PAGE   = DEF_STACK_PAGE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_boundary,
  input  logic        nmi_in,
  input  logic        irq_in,
  input  logic        brk_in,
  input  logic        psr_i_flag,
  input  logic [7:0]  sp,
  output logic [15:0] abus,
  output logic [1:0]  data_sel,
  output logic        write_en,
  output logic        sp_dec,
  output logic        b_flag,
  output logic        set_i,
  output logic        load_pcl,
  output logic        load_pch,
  output logic        busy,
  output logic        done,
  output logic [1:0]  source
);

  seq_state_t  state_q, state_d;
  int_source_t source_q, source_d;
  logic        reset_pend_q, reset_pend_d;
  logic        nmi_pending;
  logic        commit;
  logic        hijack;
  logic        nmi_clear;
  logic [15:0] vector;

  assign commit    = (state_q == ST_PUSH_P);
  assign hijack    = commit && nmi_pending &&
                     (source_q == SRC_BRK || source_q == SRC_IRQ);
  assign nmi_clear = commit && (source_q == SRC_NMI || hijack);

  nmi_edge_latch u_nmi_edge_latch (
    .clk     (clk),
    .reset   (reset),
    .nmi_in  (nmi_in),
    .clear   (nmi_clear),
    .pending (nmi_pending)
  );

  always_comb begin
    state_d      = state_q;
    source_d     = source_q;
    reset_pend_d = reset_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_boundary) begin
          if (reset_pend_q) begin
            source_d = SRC_RESET;
            state_d  = ST_DUMMY1;
          end else if (nmi_pending) begin
            source_d = SRC_NMI;
            state_d  = ST_DUMMY1;
          end else if (brk_in) begin
            source_d = SRC_BRK;
            state_d  = ST_DUMMY1;
          end else if (irq_in && !psr_i_flag) begin
            source_d = SRC_IRQ;
            state_d  = ST_DUMMY1;
          end
        end
      end
      ST_PUSH_P: begin
        state_d = ST_VEC_LO;
        if (source_q == SRC_RESET) reset_pend_d = 1'b0;
        else if (hijack)           source_d     = SRC_NMI;
      end
      ST_VEC_HI: state_d = ST_IDLE;
      default:   state_d = seq_state_t'(state_q + 3'd1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      source_q     <= SRC_RESET;
      reset_pend_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      source_q     <= source_d;
      reset_pend_q <= reset_pend_d;
    end
  end

  always_comb begin
    case (source_q)
      SRC_RESET: vector = RESET_VECTOR;
      SRC_NMI:   vector = NMI_VECTOR;
      default:   vector = IRQ_VECTOR;
    endcase
  end

  // Reset entries walk the stack pointer down without writing memory.
  always_comb begin
    abus     = 16'h0000;
    data_sel = DSEL_NONE;
    write_en = 1'b0;
    sp_dec   = 1'b0;
    b_flag   = 1'b0;
    set_i    = 1'b0;
    load_pcl = 1'b0;
    load_pch = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: begin
        abus     = {STACK_PAGE, sp};
        sp_dec   = 1'b1;
        write_en = (source_q != SRC_RESET);
        if (state_q == ST_PUSH_PCH)      data_sel = DSEL_PCH;
        else if (state_q == ST_PUSH_PCL) data_sel = DSEL_PCL;
        else begin
          data_sel = DSEL_PSR;
          b_flag   = (source_q == SRC_BRK);
        end
      end
      ST_VEC_LO: begin
        abus     = vector;
        load_pcl = 1'b1;
        set_i    = 1'b1;
      end
      ST_VEC_HI: begin
        abus     = vector + 16'd1;
        load_pch = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign source = source_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - randomized bench for interrupt_sequencer against a cycle-list model
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset, instr_boundary, nmi_in, irq_in, brk_in, psr_i_flag;
  logic [7:0]  sp;
  logic [15:0] abus;
  logic [1:0]  data_sel, source;
  logic        write_en, sp_dec, b_flag, set_i, load_pcl, load_pch, busy, done;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk(clk), .reset(reset), .instr_boundary(instr_boundary), .nmi_in(nmi_in),
    .irq_in(irq_in), .brk_in(brk_in), .psr_i_flag(psr_i_flag), .sp(sp),
    .abus(abus), .data_sel(data_sel), .write_en(write_en), .sp_dec(sp_dec),
    .b_flag(b_flag), .set_i(set_i), .load_pcl(load_pcl), .load_pch(load_pch),
    .busy(busy), .done(done), .source(source)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One entry per cycle the DUT is expected to spend busy; empty queue means idle.
  typedef struct {
    bit          stack;
    logic [15:0] addr;
    logic [1:0]  dsel;
    bit          we, dec, bf, seti, lpcl, lpch, dn, commit;
  } cyc_t;

  cyc_t       q[$];
  bit         m_reset_pend, m_nmi_pend, m_nmi_prev;
  logic [1:0] m_src;

  task automatic start_seq(input logic [1:0] s);
    cyc_t c;
    m_src = s;
    for (int k = 0; k < 5; k++) begin
      c = '{default: 0};
      if (k >= 2) begin
        c.stack = 1;
        c.dsel  = 2'(k - 1);
        c.we    = (s != 2'd0);
        c.dec   = 1;
      end
      if (k == 4) begin
        c.bf     = (s == 2'd2);
        c.commit = 1;
      end
      q.push_back(c);
    end
  endtask

  task automatic push_vector();
    cyc_t c;
    logic [15:0] vec;
    vec = (m_src == 2'd0) ? 16'hFFFC : (m_src == 2'd1) ? 16'hFFFA : 16'hFFFE;
    c = '{default: 0};
    c.addr = vec; c.seti = 1; c.lpcl = 1;
    q.push_back(c);
    c = '{default: 0};
    c.addr = vec + 16'd1; c.lpch = 1; c.dn = 1;
    q.push_back(c);
  endtask

  task automatic step(input bit r, input bit ib, input bit nmi, input bit irq,
                      input bit brk, input bit psri);
    cyc_t c;
    bit   busy_e, rise;
    logic [7:0] sp_next;
    @(negedge clk);
    busy_e = (q.size() != 0);
    c = busy_e ? q[0] : '{default: 0};
    check("busy",     {15'd0, busy},     {15'd0, busy_e});
    check("done",     {15'd0, done},     {15'd0, c.dn});
    check("abus",     abus,              c.stack ? {8'h01, sp} : c.addr);
    check("data_sel", {14'd0, data_sel}, {14'd0, c.dsel});
    check("write_en", {15'd0, write_en}, {15'd0, c.we});
    check("sp_dec",   {15'd0, sp_dec},   {15'd0, c.dec});
    check("b_flag",   {15'd0, b_flag},   {15'd0, c.bf});
    check("set_i",    {15'd0, set_i},    {15'd0, c.seti});
    check("load_pcl", {15'd0, load_pcl}, {15'd0, c.lpcl});
    check("load_pch", {15'd0, load_pch}, {15'd0, c.lpch});
    check("source",   {14'd0, source},   {14'd0, m_src});

    reset = r; instr_boundary = ib; nmi_in = nmi; irq_in = irq;
    brk_in = brk; psr_i_flag = psri;

    rise       = nmi && !m_nmi_prev;
    m_nmi_prev = nmi;
    sp_next    = c.dec ? sp - 8'd1 : sp;
    if (r) begin
      q.delete();
      m_reset_pend = 1;
      m_nmi_pend   = 0;
      m_src        = 2'd0;
    end else begin
      if (busy_e) begin
        void'(q.pop_front());
        if (c.commit) begin
          if (m_src == 2'd0) m_reset_pend = 0;
          else begin
            if (m_src != 2'd1 && m_nmi_pend) m_src = 2'd1;
            if (m_src == 2'd1) m_nmi_pend = 0;
          end
          push_vector();
        end
      end else if (ib) begin
        if (m_reset_pend)       start_seq(2'd0);
        else if (m_nmi_pend)    start_seq(2'd1);
        else if (brk)           start_seq(2'd2);
        else if (irq && !psri)  start_seq(2'd3);
      end
      if (rise) m_nmi_pend = 1;
    end
    @(posedge clk);
    #1 sp = sp_next;
  endtask

  bit nmi_r;

  initial begin
    reset = 1; instr_boundary = 0; nmi_in = 0; irq_in = 0; brk_in = 0;
    psr_i_flag = 0; sp = 8'hFD;
    repeat (2) @(posedge clk);
    #1;
    m_reset_pend = 1; m_nmi_pend = 0; m_nmi_prev = 0; m_src = 2'd0;

    // reset entry on the first boundary after reset
    repeat (10) step(0, 1, 0, 0, 0, 0);
    // IRQ masked, then unmasked
    repeat (3) step(0, 1, 0, 1, 0, 1);
    sp = 8'hFD;
    step(0, 1, 0, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0, 1);
    // BRK hijacked by an NMI edge during PUSH_PCL
    step(0, 1, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 0, 1);
    // simultaneous NMI + BRK + IRQ
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    repeat (7) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    repeat (7) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0, 0);
    // reset asserted during PUSH_PCL
    step(0, 1, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0, 0, 0);

    nmi_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) nmi_r = ~nmi_r;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, nmi_r,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
